// File: rtl/fnd_scan_ctrl.sv
// N-digit 7-segment scan controller: prescaler, digit select, blink, active-low anodes, registered BCD/dot.
// Optional leading-zero suppression is enabled with `define FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_DIV  = 500,
  localparam int SEL_W     = $clog2(NUM_DIGITS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dot_mask,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [NUM_DIGITS-1:0]     fnd_com,
  output logic [3:0]                bcd,
  output logic                      dot,
  output logic [SEL_W-1:0]          sel
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0]         presc_q, presc_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0] fnd_com_q, fnd_com_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  dot_q, dot_d;

  logic tick;
  logic blink_wrap;

  always_comb begin
    tick          = (presc_q == PW'(DIV - 1));
    blink_wrap    = (blink_cnt_q == BW'(BLINK_DIV - 1));
    presc_d       = tick ? '0 : presc_q + 1'b1;
    sel_d         = sel_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      sel_d         = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
      blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
      blink_phase_d = blink_phase_q ^ blink_wrap;
    end
  end

  logic [NUM_DIGITS-1:0] lz_sup;

`ifdef FND_LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit; the first nonzero or dotted digit ends suppression.
  logic lz_run;
  always_comb begin
    lz_sup = '0;
    lz_run = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (lz_run && (digits_in[4*k +: 4] == 4'h0) && !dot_mask[k]) begin
        lz_sup[k] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end
`else
  assign lz_sup = '0;
`endif

  logic [3:0] cur_bcd;
  logic       cur_dot;
  logic       cur_blank;

  always_comb begin
    cur_bcd   = 4'hF;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    fnd_com_d = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        cur_bcd   = digits_in[4*k +: 4];
        cur_dot   = dot_mask[k];
        cur_blank = (blink_mask[k] && blink_phase_q) || lz_sup[k];
        fnd_com_d[k] = !en;
      end
    end
    bcd_d = (!en || cur_blank) ? 4'hF : cur_bcd;
    dot_d = en && !cur_blank && cur_dot;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q       <= '0;
      sel_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      fnd_com_q     <= '1;
      bcd_q         <= 4'hF;
      dot_q         <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      sel_q         <= sel_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      fnd_com_q     <= fnd_com_d;
      bcd_q         <= bcd_d;
      dot_q         <= dot_d;
    end
  end

  assign fnd_com = fnd_com_q;
  assign bcd     = bcd_q;
  assign dot     = dot_q;
  assign sel     = sel_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: directed steps plus random inputs against a cycle-count model.
module tb_fnd_scan_ctrl;

  localparam int ND    = 4;
  localparam int DIV   = 4;
  localparam int BLINK = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [15:0]   digits_in;
  logic [3:0]    dot_mask;
  logic [3:0]    blink_mask;
  logic [3:0]    fnd_com;
  logic [3:0]    bcd;
  logic          dot;
  logic [1:0]    sel;

  int errors = 0;
  int checks = 0;
  int tcnt   = 0;

  fnd_scan_ctrl #(
    .NUM_DIGITS(ND),
    .CLK_HZ(40),
    .SCAN_HZ(10),
    .BLINK_DIV(BLINK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .digits_in(digits_in),
    .dot_mask(dot_mask),
    .blink_mask(blink_mask),
    .fnd_com(fnd_com),
    .bcd(bcd),
    .dot(dot),
    .sel(sel)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset was last released.
  always @(posedge clk or posedge reset) begin
    if (reset) tcnt <= 0;
    else       tcnt <= tcnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected display after n completed edges, given the inputs sampled at the next edge.
  task automatic model(input int n, input logic en_v, input logic [15:0] dg,
                       input logic [3:0] dm, input logic [3:0] bm,
                       output logic [3:0] ecom, output logic [3:0] ebcd, output logic edot);
    int s;
    int ph;
    int keep_from;
    logic [15:0] dgv;
    s  = (n / DIV) % ND;
    ph = (n / (DIV * BLINK)) % 2;
    dgv = dg;
    keep_from = ND - 1;
`ifdef FND_LEADING_ZERO_BLANK_EN
    keep_from = 0;
    for (int k = 0; k < ND; k++)
      if (dgv[4*k +: 4] != 4'h0 || dm[k]) keep_from = k;
`endif
    if (!en_v) begin
      ecom = 4'b1111; ebcd = 4'hF; edot = 1'b0;
    end else begin
      ecom = ~(4'b0001 << s);
      ebcd = dgv[4*s +: 4];
      edot = dm[s];
      if ((bm[s] && ph == 1) || s > keep_from) begin
        ebcd = 4'hF; edot = 1'b0;
      end
    end
  endtask

  task automatic check_cycle(input string tag);
    logic [3:0] ecom, ebcd;
    logic edot;
    model(tcnt - 1, en, digits_in, dot_mask, blink_mask, ecom, ebcd, edot);
    chk({tag, ".com"}, 32'(fnd_com), 32'(ecom));
    chk({tag, ".bcd"}, 32'(bcd), 32'(ebcd));
    chk({tag, ".dot"}, 32'(dot), 32'(edot));
    chk({tag, ".sel"}, 32'(sel), 32'((tcnt / DIV) % ND));
  endtask

  task automatic run(input int ncyc, input string tag);
    repeat (ncyc) begin
      @(negedge clk);
      check_cycle(tag);
    end
  endtask

  task automatic randomize_inputs();
    logic [15:0] dg;
    for (int i = 0; i < ND; i++)
      dg[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    digits_in  = dg;
    dot_mask   = 4'($urandom_range(0, 15));
    blink_mask = 4'($urandom_range(0, 15));
    en         = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; digits_in = 16'h0; dot_mask = 4'h0; blink_mask = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst.com", 32'(fnd_com), 32'hF);
    chk("rst.bcd", 32'(bcd), 32'hF);
    chk("rst.dot", 32'(dot), 32'h0);
    chk("rst.sel", 32'(sel), 32'h0);

    reset = 1'b0; en = 1'b1; digits_in = 16'h1234;
    @(negedge clk);
    chk("first.com", 32'(fnd_com), 32'b1110);
    chk("first.bcd", 32'(bcd), 32'h4);
    check_cycle("first");
    run(4, "scan");
    chk("d1.com", 32'(fnd_com), 32'b1101);
    chk("d1.bcd", 32'(bcd), 32'h3);
    run(31, "scan");

    dot_mask = 4'b0100; blink_mask = 4'b0001;
    run(40, "blink");

    en = 1'b0;
    run(10, "dark");
    en = 1'b1;
    run(12, "reen");

    digits_in = 16'h0050; dot_mask = 4'h0; blink_mask = 4'h0;
    run(16, "lz50");
    digits_in = 16'h0000;
    run(16, "lz00");
    digits_in = 16'h0007; dot_mask = 4'b0100;
    run(16, "lz07");
    digits_in = 16'hABCE; dot_mask = 4'h0;
    run(16, "hex");

    repeat (400) begin
      @(negedge clk);
      check_cycle("rand");
      randomize_inputs();
    end

    en = 1'b1; digits_in = 16'h1234; dot_mask = 4'h0; blink_mask = 4'h0;
    for (int i = 0; i < 64 && sel !== 2'd2; i++) @(negedge clk);
    chk("wait_sel2", 32'(sel), 32'd2);
    #3 reset = 1'b1;
    #1;
    chk("arst.com", 32'(fnd_com), 32'hF);
    chk("arst.bcd", 32'(bcd), 32'hF);
    chk("arst.dot", 32'(dot), 32'h0);
    chk("arst.sel", 32'(sel), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run(20, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
